// File: rtl/lrc_frame_checker.sv
// lrc_frame_checker
//   Brackets each byte frame around an upstream running-LRC stage. It pulses
//   lrc_clear at frame start and waits SETTLE_CYCLES after frame_end. It then
//   compares lrc_in against the received check byte and presents pass/fail on
//   a valid/ready result port. Accepted results feed saturating pass/fail
//   counters.
//
//   Optional feature: define LRC_CHECK_TIMEOUT_EN to abort frames that stay
//   in ACTIVE for TIMEOUT_CYCLES cycles without frame_end. An aborted frame
//   reports result_timeout=1 and result_pass=0.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   lrc_in[7:0]     running LRC from upstream stage
//   frame_start     one-cycle pulse, frame begins
//   frame_end       one-cycle pulse, last byte delivered, check_in valid
//   check_in[7:0]   received check byte (sampled with frame_end)
//   lrc_clear       one-cycle clear pulse to upstream LRC
//   result_valid    result available, held until result_ready
//   result_ready    consumer accepts result
//   result_pass     lrc_in matched check_in
//   result_timeout  frame aborted by timeout
//   proto_err       sticky protocol-error flag, cleared only by rst
//   pass_count      accepted passing frames, saturating
//   fail_count      accepted failing/timed-out frames, saturating
module lrc_frame_checker #(
   parameter int SETTLE_CYCLES  = 1,
   parameter int CNT_W          = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       lrc_in,
   input  logic             frame_start,
   input  logic             frame_end,
   input  logic [7:0]       check_in,
   output logic             lrc_clear,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             result_pass,
   output logic             result_timeout,
   output logic             proto_err,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count
);

   typedef enum logic [1:0] {IDLE, ACTIVE, SETTLE, REPORT} state_t;

   state_t     state, state_nxt;
   logic [7:0] expected;
   logic [3:0] settle_cnt;

   logic clear_set, perr_set, latch, sample, accept, restart, timeout_hit;

`ifdef LRC_CHECK_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TCNT_W-1:0] tcnt;

   // tcnt is 0 in the first ACTIVE cycle, so the hit lands on the
   // TIMEOUT_CYCLES-th ACTIVE cycle and REPORT follows on the next one.
   assign timeout_hit = (state == ACTIVE) && (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst)
         tcnt <= '0;
      else if (state != ACTIVE || restart)
         tcnt <= '0;
      else
         tcnt <= tcnt + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      clear_set = 1'b0;
      perr_set  = 1'b0;
      latch     = 1'b0;
      sample    = 1'b0;
      accept    = 1'b0;
      restart   = 1'b0;
      case (state)
         IDLE: begin
            if (frame_end) perr_set = 1'b1;
            if (frame_start) begin
               clear_set = 1'b1;
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (frame_end) begin
               // frame_end wins over a coincident frame_start
               latch     = 1'b1;
               perr_set  = frame_start;
               state_nxt = SETTLE;
            end else if (frame_start) begin
               perr_set  = 1'b1;
               clear_set = 1'b1;
               restart   = 1'b1;
            end else if (timeout_hit) begin
               state_nxt = REPORT;
            end
         end
         SETTLE: begin
            perr_set = frame_start | frame_end;
            if (settle_cnt == 4'd1) begin
               sample    = 1'b1;
               state_nxt = REPORT;
            end
         end
         REPORT: begin
            perr_set = frame_start | frame_end;
            if (result_ready) begin
               accept    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         expected       <= '0;
         settle_cnt     <= '0;
         lrc_clear      <= 1'b0;
         proto_err      <= 1'b0;
         result_pass    <= 1'b0;
         result_timeout <= 1'b0;
         pass_count     <= '0;
         fail_count     <= '0;
      end else begin
         lrc_clear <= clear_set;
         proto_err <= proto_err | perr_set;
         if (latch) begin
            expected   <= check_in;
            settle_cnt <= 4'(SETTLE_CYCLES);
         end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt - 1'b1;
         end
         if (sample) begin
            result_pass    <= (lrc_in == expected);
            result_timeout <= 1'b0;
         end else if (state == ACTIVE && state_nxt == REPORT) begin
            result_pass    <= 1'b0;
            result_timeout <= 1'b1;
         end
         if (accept) begin
            if (result_pass) begin
               if (pass_count != '1) pass_count <= pass_count + 1'b1;
            end else begin
               if (fail_count != '1) fail_count <= fail_count + 1'b1;
            end
         end
      end
   end

   assign result_valid = (state == REPORT);

endmodule
